// File: rtl/rom_burst_loader_if.sv
// rom_burst_loader_if: start/len request, ROM read bus and indexed buffer read port; slave = loader, master = requester/ROM side.
interface rom_burst_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 32,
  parameter int LEN_W  = $clog2(DEPTH + 1),
  parameter int IDX_W  = $clog2(DEPTH)
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rden;
  logic [DATA_W-1:0] rom_q;
  logic              busy;
  logic              done;
  logic              err;
  logic              data_valid;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  modport master (
    output start, base_addr, len, rom_q, rd_idx,
    input  rom_addr, rom_rden, busy, done, err, data_valid, rd_data
  );
  modport slave (
    input  start, base_addr, len, rom_q, rd_idx,
    output rom_addr, rom_rden, busy, done, err, data_valid, rd_data
  );
endinterface

// File: rtl/rom_burst_loader.sv
// rom_burst_loader: pipelined burst read of len words from a latency-ROM_LATENCY ROM into a buffer; ports clk, reset (sync, active-high), bus (slave: start/base_addr/len in, rom_addr/rom_rden out, rom_q in, busy/done/err/data_valid out, rd_idx in, rd_data out).
module rom_burst_loader #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 32,
  parameter int ROM_LATENCY = 1
) (
  input logic             clk,
  input logic             reset,
  rom_burst_loader_if.slave bus
);
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]  len_r, issue_cnt, wr_cnt, wr_nx;
  logic [ROM_LATENCY-1:0] pipe;
  logic              pipe_out, accept, bad_len, err_r, err_pulse, dv_r;
  logic [DATA_W-1:0] buffer [DEPTH];
  assign accept   = state == IDLE && bus.start;
  assign bad_len  = bus.len == '0 || bus.len > LEN_W'(DEPTH);
  assign pipe_out = pipe[ROM_LATENCY-1];
  assign wr_nx    = wr_cnt + LEN_W'(pipe_out);
  // FIN is entered on the cycle the last word is captured, so done lands len+ROM_LATENCY+1 cycles after start.
  always_comb begin
    state_nx        = state;
    bus.rom_rden    = 1'b0;
    bus.rom_addr    = '0;
    bus.busy        = state == ISSUE || state == DRAIN;
    bus.done        = state == FIN || err_pulse;
    bus.err         = err_r;
    bus.data_valid  = dv_r;
    state_nx = state == IDLE  ? (accept && !bad_len ? ISSUE : IDLE) :
               state == ISSUE ? (issue_cnt == len_r - LEN_W'(1) ? DRAIN : ISSUE) :
               state == DRAIN ? (wr_nx == len_r ? FIN : DRAIN) : IDLE;
    if (state == ISSUE) begin
      bus.rom_rden = 1'b1;
      bus.rom_addr = base_r + ADDR_W'(issue_cnt);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      base_r    <= '0;
      len_r     <= '0;
      issue_cnt <= '0;
      wr_cnt    <= '0;
      pipe      <= '0;
      err_r     <= 1'b0;
      err_pulse <= 1'b0;
      dv_r      <= 1'b0;
    end else begin
      state     <= state_nx;
      err_pulse <= accept && bad_len;
      pipe      <= ROM_LATENCY'({pipe, state == ISSUE});
      if (accept) begin
        base_r    <= bus.base_addr;
        len_r     <= bus.len;
        err_r     <= bad_len;
        dv_r      <= 1'b0;
        issue_cnt <= '0;
        wr_cnt    <= '0;
      end else begin
        issue_cnt <= state == ISSUE ? issue_cnt + LEN_W'(1) : issue_cnt;
        wr_cnt    <= wr_nx;
        dv_r      <= dv_r || state_nx == FIN;
      end
    end
  end
  always_ff @(posedge clk)
    if (pipe_out && !reset) buffer[wr_cnt[IDX_W-1:0]] <= bus.rom_q;
  assign bus.rd_data = 32'(bus.rd_idx) < DEPTH ? buffer[bus.rd_idx] : '0;
endmodule

// File: tb/tb_rom_burst_loader.sv
// tb_rom_burst_loader: directed bench for rom_burst_loader with ROM latency 1 and 3 and a DEPTH=24 range-check instance.
module tb_rom_burst_loader;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  rom_burst_loader_if b0();
  rom_burst_loader_if b3();
  rom_burst_loader_if #(.DEPTH(24)) b24();
  rom_burst_loader #(.ROM_LATENCY(1)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  rom_burst_loader #(.ROM_LATENCY(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));
  rom_burst_loader #(.DEPTH(24)) u24 (.clk(clk), .reset(reset), .bus(b24.slave));
  function automatic logic [7:0] rom(input logic [5:0] a);
    return {2'b00, a} ^ 8'hA5;
  endfunction
  logic [7:0] q1, q2;
  always @(posedge clk) begin
    b0.rom_q <= rom(b0.rom_addr);
    q1 <= rom(b3.rom_addr);
    q2 <= q1;
    b3.rom_q <= q2;
  end
  int errors = 0, checks = 0;
  int addrs[$];
  int done_cyc, done_cnt, busy_lo, busy_hi, rden_lo, rden_hi;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic drive(input int u, input logic s, input int b, input int l);
    if (u == 3) begin b3.start = s; b3.base_addr = 6'(b); b3.len = 6'(l); end
    else begin b0.start = s; b0.base_addr = 6'(b); b0.len = 6'(l); end
  endtask
  task automatic go(input int u, input int b, input int l, input int cycles, input int inj);
    logic rden, busy, done;
    int addr;
    addrs.delete();
    done_cyc = -1; done_cnt = 0; busy_lo = -1; busy_hi = -1; rden_lo = -1; rden_hi = -1;
    @(negedge clk); drive(u, 1, b, l);
    @(posedge clk); #1 drive(u, 0, b, l);
    for (int n = 1; n <= cycles; n++) begin
      @(negedge clk);
      if (n == inj) drive(u, 1, 10, l);
      else if (n == inj + 1) drive(u, 0, b, l);
      rden = u == 3 ? b3.rom_rden : b0.rom_rden;
      addr = u == 3 ? int'(b3.rom_addr) : int'(b0.rom_addr);
      busy = u == 3 ? b3.busy : b0.busy;
      done = u == 3 ? b3.done : b0.done;
      if (rden) begin addrs.push_back(addr); if (rden_lo < 0) rden_lo = n; rden_hi = n; end
      if (busy) begin if (busy_lo < 0) busy_lo = n; busy_hi = n; end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = n; end
    end
  endtask
  task automatic rd(input int u, input int idx, input int exp, input string tag);
    if (u == 3) b3.rd_idx = 5'(idx); else if (u == 24) b24.rd_idx = 5'(idx); else b0.rd_idx = 5'(idx);
    #1 check(tag, u == 3 ? int'(b3.rd_data) : u == 24 ? int'(b24.rd_data) : int'(b0.rd_data), exp);
  endtask
  task automatic addr_seq(input string tag, input int b, input int l);
    check({tag, "_naddr"}, addrs.size(), l);
    for (int i = 0; i < l && i < addrs.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), addrs[i], (b + i) % 64);
  endtask
  initial begin
    #200000 $display("FAIL watchdog got=timeout exp=finish"); $fatal(1, "watchdog");
  end
  initial begin
    drive(0, 0, 0, 0); drive(3, 0, 0, 0);
    b0.rd_idx = 0; b3.rd_idx = 0; b24.rd_idx = 0;
    b24.start = 0; b24.base_addr = 0; b24.len = 0; b24.rom_q = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", b0.busy, 0); check("rst_done", b0.done, 0);
    check("rst_err", b0.err, 0); check("rst_dv", b0.data_valid, 0);
    check("rst_rden", b0.rom_rden, 0); check("rst_addr", b0.rom_addr, 0);
    reset = 0;
    go(0, 0, 32, 40, -1);
    addr_seq("full", 0, 32);
    check("full_rden_lo", rden_lo, 1); check("full_rden_hi", rden_hi, 32);
    check("full_done_cyc", done_cyc, 34); check("full_done_cnt", done_cnt, 1);
    check("full_busy_lo", busy_lo, 1); check("full_busy_hi", busy_hi, 33);
    check("full_dv", b0.data_valid, 1); check("full_err", b0.err, 0);
    for (int i = 0; i < 32; i++) rd(0, i, int'(rom(6'(i))), $sformatf("full_buf%0d", i));
    go(0, 60, 8, 14, -1);
    addr_seq("wrap", 60, 8);
    check("wrap_done_cyc", done_cyc, 10);
    rd(0, 0, int'(rom(6'd60)), "wrap_buf0"); rd(0, 4, int'(rom(6'd0)), "wrap_buf4");
    rd(0, 7, int'(rom(6'd3)), "wrap_buf7"); rd(0, 8, int'(rom(6'd8)), "wrap_stale8");
    for (int k = 0; k < 2; k++) begin
      go(0, 0, k ? 33 : 0, 6, -1);
      check($sformatf("bad%0d_done_cyc", k), done_cyc, 1);
      check($sformatf("bad%0d_done_cnt", k), done_cnt, 1);
      check($sformatf("bad%0d_err", k), b0.err, 1);
      check($sformatf("bad%0d_dv", k), b0.data_valid, 0);
      check($sformatf("bad%0d_rden", k), addrs.size(), 0);
      check($sformatf("bad%0d_busy", k), busy_lo, -1);
    end
    go(0, 8, 4, 10, -1);
    check("clr_err", b0.err, 0); check("clr_done_cyc", done_cyc, 6); check("clr_dv", b0.data_valid, 1);
    go(0, 20, 16, 22, 5);
    addr_seq("inj", 20, 16);
    check("inj_done_cnt", done_cnt, 1); check("inj_done_cyc", done_cyc, 18);
    for (int i = 0; i < 16; i++) rd(0, i, int'(rom(6'(20 + i))), $sformatf("inj_buf%0d", i));
    @(negedge clk); drive(0, 1, 30, 20);
    @(posedge clk); #1 drive(0, 0, 30, 20);
    repeat (10) @(negedge clk);
    check("mid_rden", b0.rom_rden, 1); check("mid_addr", b0.rom_addr, 39);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("mr_busy", b0.busy, 0); check("mr_done", b0.done, 0); check("mr_err", b0.err, 0);
    check("mr_dv", b0.data_valid, 0); check("mr_rden", b0.rom_rden, 0); check("mr_addr", b0.rom_addr, 0);
    go(0, 5, 4, 12, -1);
    addr_seq("post", 5, 4);
    check("post_done_cyc", done_cyc, 6); check("post_done_cnt", done_cnt, 1); check("post_dv", b0.data_valid, 1);
    for (int i = 0; i < 4; i++) rd(0, i, int'(rom(6'(5 + i))), $sformatf("post_buf%0d", i));
    for (int i = 4; i < 8; i++) rd(0, i, int'(rom(6'(30 + i))), $sformatf("post_stale%0d", i));
    go(3, 0, 32, 40, -1);
    addr_seq("l3", 0, 32);
    check("l3_done_cyc", done_cyc, 36); check("l3_done_cnt", done_cnt, 1);
    check("l3_busy_hi", busy_hi, 35); check("l3_dv", b3.data_valid, 1);
    for (int i = 0; i < 32; i++) rd(3, i, int'(rom(6'(i))), $sformatf("l3_buf%0d", i));
    rd(24, 30, 0, "oor_idx30"); rd(24, 24, 0, "oor_idx24");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
